// File: rtl/wave_capture_buf.sv
// wave_capture_buf: decimating waveform capture into a circular RAM with a
// programmable pre-trigger window, rising-edge trigger and oldest-first
// readout on a valid/ready stream.
//
// Stream handshake: a readout sample transfers on a cycle where dout_valid
// and dout_ready are both high. While dout_valid is high and dout_ready is
// low, dout and dout_last hold their values. dout_valid only drops after a
// transfer, or when abort is pulsed.
module wave_capture_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 10,
    parameter int DEC_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trigger,
    input  logic              arm,
    input  logic              abort,
    input  logic              single_mode,
    input  logic [CNT_W-1:0]  pre_len,
    input  logic [DEC_W-1:0]  dec_rate,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_READOUT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Capture-side registers
    logic              trig_d;
    logic [DEC_W-1:0]  dec_lat;
    logic [DEC_W-1:0]  dec_cnt;
    logic [CNT_W-1:0]  pre_lat;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Readout-side registers: one read in flight, output register, skid
    logic [AW-1:0]     rd_addr;
    logic [CNT_W-1:0]  rd_left;
    logic              fly_v;
    logic              fly_l;
    logic [DATA_W-1:0] ram_q;
    logic              out_v;
    logic              out_l;
    logic [DATA_W-1:0] out_d;
    logic              sk_v;
    logic              sk_l;
    logic [DATA_W-1:0] sk_d;

    logic              edge_det;
    logic [CNT_W-1:0]  post_target;
    logic              post_full;
    logic              capt_state;
    logic              dec_hit;
    logic              store;
    logic              hs;
    logic              last_hs;
    logic [1:0]        occ;
    logic              issue;
    logic              enter_pre;
    logic              arm_ok;

    assign edge_det    = trigger & ~trig_d;
    assign post_target = DEPTH_C - pre_lat;
    assign post_full   = (cnt == post_target);
    // POST stops writing once its quota is met so the frame is not overrun
    // during the single cycle spent handing over to READOUT.
    assign capt_state  = (state == S_PRE) || (state == S_ARMED) ||
                         ((state == S_POST) && !post_full);
    assign dec_hit     = (dec_cnt == dec_lat);
    assign store       = capt_state && din_valid && dec_hit && !abort;
    assign hs          = out_v && dout_ready;
    assign last_hs     = hs && out_l;
    // Entries held or on their way after this cycle; at most two may exist.
    assign occ         = {1'b0, out_v} + {1'b0, sk_v} + {1'b0, fly_v} - {1'b0, hs};
    assign issue       = (state == S_READOUT) && (rd_left != '0) && (occ < 2'd2) && !abort;
    assign arm_ok      = ((state == S_IDLE) || (state == S_DONE)) && arm;
    assign enter_pre   = (state_nxt == S_PRE) && (state != S_PRE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (arm)          state_nxt = S_PRE;
                S_PRE:          if (cnt == pre_lat) state_nxt = S_ARMED;
                S_ARMED:        if (edge_det)     state_nxt = S_POST;
                S_POST:         if (post_full)    state_nxt = S_READOUT;
                S_READOUT:      if (last_hs)      state_nxt = single_mode ? S_DONE : S_PRE;
                default:                          state_nxt = S_IDLE;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        busy    = (state != S_IDLE) && (state != S_DONE);
        state_o = state;
    end

    // Trigger history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= trigger;
    end

    // Capture control: latched settings, decimation and sample counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_lat <= '0;
            dec_lat <= '0;
            dec_cnt <= '0;
            cnt     <= '0;
        end else if (abort) begin
            dec_cnt <= '0;
            cnt     <= '0;
        end else begin
            if (arm_ok) begin
                pre_lat <= (pre_len >= DEPTH_C) ? DEPTH_M1 : pre_len;
                dec_lat <= dec_rate;
            end
            if (enter_pre) begin
                dec_cnt <= '0;
                cnt     <= '0;
            end else begin
                if (capt_state && din_valid)
                    dec_cnt <= dec_hit ? '0 : dec_cnt + DEC_W'(1);
                case (state)
                    S_PRE:   if (store) cnt <= cnt + CNT_W'(1);
                    // The sample written in the edge cycle is the first POST sample.
                    S_ARMED: cnt <= (edge_det && store) ? CNT_W'(1) : '0;
                    S_POST:  if (store) cnt <= cnt + CNT_W'(1);
                    default: cnt <= '0;
                endcase
            end
        end
    end

    // Write pointer advances once per stored sample and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     wr_ptr <= '0;
        else if (store) wr_ptr <= wr_ptr + AW'(1);
    end

    // Sample RAM: synchronous write, registered read
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= din;
        if (issue) ram_q <= mem[rd_addr];
    end

    // Readout: address generation, in-flight tag, output and skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_left <= '0;
            fly_v   <= 1'b0;
            fly_l   <= 1'b0;
            out_v   <= 1'b0;
            out_l   <= 1'b0;
            out_d   <= '0;
            sk_v    <= 1'b0;
            sk_l    <= 1'b0;
            sk_d    <= '0;
        end else if (abort) begin
            rd_left <= '0;
            fly_v   <= 1'b0;
            fly_l   <= 1'b0;
            out_v   <= 1'b0;
            out_l   <= 1'b0;
            sk_v    <= 1'b0;
            sk_l    <= 1'b0;
        end else begin
            // The write pointer is the oldest sample once POST has finished.
            if ((state == S_POST) && post_full) begin
                rd_addr <= wr_ptr;
                rd_left <= DEPTH_C;
            end else if (issue) begin
                rd_addr <= rd_addr + AW'(1);
                rd_left <= rd_left - CNT_W'(1);
            end
            fly_v <= issue;
            fly_l <= issue && (rd_left == CNT_W'(1));

            if (hs || !out_v) begin
                if (sk_v) begin
                    out_v <= 1'b1;
                    out_d <= sk_d;
                    out_l <= sk_l;
                    sk_v  <= fly_v;
                    sk_d  <= ram_q;
                    sk_l  <= fly_l;
                end else if (fly_v) begin
                    out_v <= 1'b1;
                    out_d <= ram_q;
                    out_l <= fly_l;
                end else begin
                    out_v <= 1'b0;
                    out_l <= 1'b0;
                end
            end else if (fly_v) begin
                sk_v <= 1'b1;
                sk_d <= ram_q;
                sk_l <= fly_l;
            end
        end
    end

    assign dout       = out_d;
    assign dout_valid = out_v;
    assign dout_last  = out_l;

endmodule

// File: tb/tb_wave_capture_buf.sv
// Bench for wave_capture_buf at DEPTH=16: directed captures with a ramp
// source, scoreboard of expected readout samples checked by a monitor.
module tb_wave_capture_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int DEC_W  = 3;
    localparam int EW     = DATA_W + 1;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              trigger = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              single_mode = 1'b1;
    logic [CNT_W-1:0]  pre_len = '0;
    logic [DEC_W-1:0]  dec_rate = '0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready = 1'b1;
    logic              dout_last;
    logic              busy;
    logic [2:0]        state_o;

    wave_capture_buf #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DEC_W(DEC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .trigger(trigger), .arm(arm), .abort(abort), .single_mode(single_mode),
        .pre_len(pre_len), .dec_rate(dec_rate), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .state_o(state_o)
    );

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    // Source configuration
    int ramp_on = 0;
    int ramp_v = 0;
    int trig_at = 1000;
    int hold_until = 0;
    logic trig_idle = 1'b0;
    int rdy_mode = 0;
    int cyc = 0;
    int hs_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: one cycle of source, trigger and ready stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ramp_on != 0) begin
            din       = DATA_W'(ramp_v);
            din_valid = 1'b1;
            trigger   = (ramp_v < hold_until) || (ramp_v >= trig_at);
            ramp_v++;
        end else begin
            din_valid = 1'b0;
            trigger   = trig_idle;
        end
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: dout_ready = 1'b0;
        endcase
    endtask

    task automatic push_frame(input int first, input int step);
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DEPTH; k++) begin
            v = DATA_W'(first + k * step);
            exp_q.push_back({(k == DEPTH - 1), v});
        end
    endtask

    task automatic start_capture(input int pre, input int dec, input int t_at, input int hold);
        ramp_on    = 0;
        pre_len    = CNT_W'(pre);
        dec_rate   = DEC_W'(dec);
        trig_at    = t_at;
        hold_until = hold;
        tick();
        arm = 1'b1;
        ramp_v  = 0;
        ramp_on = 1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state_o) != s && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(state_o), s);
    endtask

    task automatic wait_drained(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: scoreboard pops on each handshake, stall stability check
    logic              prev_stall = 1'b0;
    logic              prev_abort = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    logic              prev_l = 1'b0;
    logic [EW-1:0]     e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                checks++;
                if (!dout_valid || dout !== prev_d || dout_last !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                             dout_valid, dout, dout_last, prev_d, prev_l);
                end
            end
            if (dout_valid && dout_ready) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL readout_extra: got d=%0d l=%0b expected no sample", dout, dout_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_last, dout} !== e) begin
                        errors++;
                        $display("FAIL readout: got d=%0d l=%0b expected d=%0d l=%0b",
                                 dout, dout_last, e[DATA_W-1:0], e[DATA_W]);
                    end
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_abort = abort;
            prev_d     = dout;
            prev_l     = dout_last;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_valid"}, int'(dout_valid), 0);
        check({tag, "_last"}, int'(dout_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_state"}, int'(state_o), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic capture: pre 4, edge at 20 -> 16..31
        single_mode = 1'b1;
        rdy_mode = 0;
        hs_cnt = 0;
        push_frame(16, 1);
        start_capture(4, 0, 20, 0);
        check("basic_pre_state", int'(state_o), 1);
        check("basic_busy", int'(busy), 1);
        wait_state(4, 100, "basic_readout");
        ramp_on = 0;
        wait_drained(100, "basic_drain");
        tick();
        check("basic_done", int'(state_o), 5);
        check("basic_busy_done", int'(busy), 0);
        check("basic_hs", hs_cnt, DEPTH);

        // Decimation: keep 1 of 3, pre 0, edge at 30 -> 32,35,...,77
        push_frame(32, 3);
        start_capture(0, 2, 30, 0);
        wait_state(4, 200, "dec_readout");
        ramp_on = 0;
        wait_drained(100, "dec_drain");
        tick();
        check("dec_busy", int'(busy), 0);
        check("dec_done", int'(state_o), 5);

        // Backpressure with ready pattern 1,0,0,1
        rdy_mode = 1;
        hs_cnt = 0;
        push_frame(16, 1);
        start_capture(4, 0, 20, 0);
        wait_state(4, 100, "bp_readout");
        ramp_on = 0;
        wait_drained(200, "bp_drain");
        tick();
        check("bp_hs", hs_cnt, DEPTH);
        check("bp_done", int'(state_o), 5);
        rdy_mode = 0;

        // Edge gating: trigger high through PRE, falls at 10, rises at 14
        trig_idle = 1'b1;
        tick();
        push_frame(10, 1);
        start_capture(4, 0, 14, 10);
        wait_state(4, 100, "gate_readout");
        ramp_on = 0;
        trig_idle = 1'b0;
        wait_drained(100, "gate_drain");

        // Auto-rearm: two frames, then abort a stalled third readout
        single_mode = 1'b0;
        push_frame(16, 1);
        start_capture(4, 0, 20, 0);
        wait_state(4, 100, "rearm1_readout");
        ramp_on = 0;
        wait_state(1, 100, "rearm1_pre");
        check("rearm1_empty", exp_q.size(), 0);
        push_frame(116, 1);
        trig_at = 120;
        hold_until = 0;
        ramp_v = 100;
        ramp_on = 1;
        wait_state(4, 100, "rearm2_readout");
        ramp_on = 0;
        wait_state(1, 100, "rearm2_pre");
        check("rearm2_empty", exp_q.size(), 0);
        rdy_mode = 2;
        trig_at = 220;
        ramp_v = 200;
        ramp_on = 1;
        wait_state(4, 100, "abort_readout");
        ramp_on = 0;
        for (int n = 0; n < 10 && !dout_valid; n++) tick();
        check("abort_pre_valid", int'(dout_valid), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", int'(state_o), 0);
        check("abort_valid", int'(dout_valid), 0);
        check("abort_last", int'(dout_last), 0);
        rdy_mode = 0;

        // arm and abort together stay in IDLE
        tick();
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", int'(state_o), 0);
        check("arm_abort_busy", int'(busy), 0);

        // Clamp: pre_len 20 acts as 15 -> frame 5..20, one POST sample
        single_mode = 1'b1;
        push_frame(5, 1);
        start_capture(20, 0, 20, 0);
        wait_state(4, 100, "clamp_readout");
        ramp_on = 0;
        wait_drained(100, "clamp_drain");
        tick();
        check("clamp_done", int'(state_o), 5);

        // Reset during POST, then a normal capture
        start_capture(4, 0, 20, 0);
        wait_state(3, 100, "rst_post");
        rst_n = 1'b0;
        #2;
        check_zero_outputs("midrst");
        ramp_on = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle", int'(state_o), 0);
        push_frame(16, 1);
        start_capture(4, 0, 20, 0);
        wait_state(4, 100, "post_rst_readout");
        ramp_on = 0;
        wait_drained(100, "post_rst_drain");
        tick();
        check("post_rst_done", int'(state_o), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
